adder_bist: RTL and testbench

Self-checking stimulus/response engine for the carry-select adder family: the driving end of the adder's `a`/`b`/`cin` → `sum`/`cout` interface. On a start pulse it walks every operand combination, waits a programmable settle time, and compares the adder outputs against an internal golden sum. It then reports pass/fail, a mismatch count and the first failing vector. It sits beside the adder under test in on-chip BIST or FPGA bring-up builds.

---
 rtl/adder_bist_pkg.sv | 18 +
 rtl/adder_bist_checker.sv | 58 +++++
 rtl/adder_bist.sv | 115 +++++++++++
 tb/tb_adder_bist.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder BIST engine.
package adder_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int ERR_W = 16;

  // One vector is {a, b, cin}: two operands plus the carry-in bit.
  function automatic int vec_width(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/adder_bist_checker.sv
// Golden-sum compare, saturating mismatch counter and first-failure capture.
module adder_bist_checker
  import adder_bist_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               check,
  input  logic [2*WIDTH:0]   vec,
  input  logic [WIDTH-1:0]   dut_sum,
  input  logic               dut_cout,
  output logic               mismatch,
  output logic [ERR_W-1:0]   err_count,
  output logic               fail_valid,
  output logic [2*WIDTH:0]   fail_vec
);

  localparam int VW = vec_width(WIDTH);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [WIDTH:0]   exp_total;

  assign op_a   = vec[VW-1 -: WIDTH];
  assign op_b   = vec[WIDTH:1];
  assign op_cin = vec[0];

  // Golden sum kept at WIDTH+1 bits so the carry-out is compared too.
  always_comb begin
    exp_total = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin};
    mismatch  = ({dut_cout, dut_sum} != exp_total);
  end

  // Result registers: cleared on run start, updated at the end of each CHECK cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else if (clear) begin
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else if (check && mismatch) begin
      if (err_count != {ERR_W{1'b1}}) begin
        err_count <= err_count + 1'b1;
      end
      if (!fail_valid) begin
        fail_valid <= 1'b1;
        fail_vec   <= vec;
      end
    end
  end

endmodule

// File: rtl/adder_bist.sv
// Exhaustive stimulus/response BIST engine for a WIDTH-bit adder.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_IDLE   | waiting for start; operands and results hold
//   ST_SETTLE | current vector driven, counting down the settle time
//   ST_CHECK  | adder outputs sampled and compared against golden
//   ST_FINISH | done pulse; busy drops at the end of this cycle
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   dut_a,
  output logic [WIDTH-1:0]   dut_b,
  output logic               dut_cin,
  input  logic [WIDTH-1:0]   dut_sum,
  input  logic               dut_cout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic               fail_valid,
  output logic [2*WIDTH:0]   fail_vec
);

  localparam int VW = vec_width(WIDTH);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t          state;
  logic [VW-1:0]   vec;
  logic [CW-1:0]   settle_cnt;
  logic            accept;
  logic            checking;
  logic            mismatch;

  // The vector register is the operand register: {a, b, cin} with cin as LSB.
  assign {dut_a, dut_b, dut_cin} = vec;

  assign accept   = (state == ST_IDLE) && start;
  assign checking = (state == ST_CHECK);

  // Sequencer: walks every vector, holding each for SETTLE cycles plus one check cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            vec        <= '0;
            settle_cnt <= CW'(SETTLE - 1);
            busy       <= 1'b1;
            pass       <= 1'b0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ST_CHECK: begin
          if (vec == {VW{1'b1}}) begin
            // The final compare lands on this same edge, so fold it into pass here.
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
            state <= ST_FINISH;
          end else begin
            vec        <= vec + 1'b1;
            settle_cnt <= CW'(SETTLE - 1);
            state      <= ST_SETTLE;
          end
        end
        ST_FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  adder_bist_checker #(
    .WIDTH (WIDTH)
  ) u_checker (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (accept),
    .check      (checking),
    .vec        (vec),
    .dut_sum    (dut_sum),
    .dut_cout   (dut_cout),
    .mismatch   (mismatch),
    .err_count  (err_count),
    .fail_valid (fail_valid),
    .fail_vec   (fail_vec)
  );

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: two instances (SETTLE=1 and SETTLE=3) each driving a
// behavioural adder with selectable fault injection.
module tb_adder_bist;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, start3;
  logic [3:0]  a1, b1, sum1, a3, b3, sum3;
  logic        cin1, cout1, cin3, cout3;
  logic        busy1, done1, pass1, fv1;
  logic        busy3, done3, pass3, fv3;
  logic [15:0] err1, err3;
  logic [8:0]  fvec1, fvec3;

  int mode1, kvec1, sbit1;
  int checks, errors;

  always #5 clk = ~clk;

  // Adder under test, with optional faults:
  // 0 correct, 1 sum[0] stuck 0, 2 cout stuck 0, 3 one vector's sum[0] inverted, 4 result bit sb stuck 0
  function automatic logic [4:0] adder_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic cin, input int mode, input int k,
                                             input int sb);
    int          s;
    logic [4:0]  r;
    s = int'(a) + int'(b) + int'(cin);
    r = 5'(s);
    case (mode)
      1: r[0] = 1'b0;
      2: r[4] = 1'b0;
      3: if ({a, b, cin} == 9'(k)) r[0] = ~r[0];
      4: r[sb] = 1'b0;
      default: ;
    endcase
    return r;
  endfunction

  always_comb {cout1, sum1} = adder_model(a1, b1, cin1, mode1, kvec1, sbit1);
  always_comb {cout3, sum3} = adder_model(a3, b3, cin3, 0, 0, 0);

  adder_bist #(.WIDTH(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .dut_a(a1), .dut_b(b1), .dut_cin(cin1), .dut_sum(sum1), .dut_cout(cout1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .fail_vec(fvec1)
  );

  adder_bist #(.WIDTH(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .dut_a(a3), .dut_b(b3), .dut_cin(cin3), .dut_sum(sum3), .dut_cout(cout3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_valid(fv3), .fail_vec(fvec3)
  );

  // Reference: enumerate every operand triple in numeric order and tally bad answers.
  task automatic expect_faults(input int mode, input int k, input int sb,
                               output int n_err, output int first);
    n_err = 0;
    first = -1;
    for (int v = 0; v < 512; v++) begin
      int a, b, c, truth;
      logic [4:0] got;
      a = (v >> 5) & 15;
      b = (v >> 1) & 15;
      c = v & 1;
      truth = a + b + c;
      got = adder_model(4'(a), 4'(b), 1'(c), mode, k, sb);
      if (int'(got) != truth) begin
        n_err++;
        if (first < 0) first = v;
      end
    end
  endtask

  // Pulse start on dut1 and count edges until done; optionally re-pulse start mid-run.
  task automatic run1(input int repulse_at, output int cycles);
    @(negedge clk) start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    cycles = 0;
    while (done1 !== 1'b1 && cycles < 5000) begin
      if (cycles == repulse_at) start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      cycles++;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy1, done1, pass1, fv1, err1, fvec1, a1, b1, cin1} !== '0) begin
      errors++;
      $display("FAIL reset_in: got busy=%0b done=%0b pass=%0b fv=%0b err=%0d fvec=%h a=%h b=%h cin=%0b, want all 0",
               busy1, done1, pass1, fv1, err1, fvec1, a1, b1, cin1);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy1, done1, pass1, fv1, err1, busy3, done3, pass3, err3} !== '0) begin
      errors++;
      $display("FAIL reset_idle: busy1=%0b done1=%0b pass1=%0b err1=%0d busy3=%0b, want all 0",
               busy1, done1, pass1, err1, busy3);
    end
  endtask

  task automatic test_clean_run();
    int cyc;
    mode1 = 0;
    run1(-1, cyc);
    checks++;
    if (cyc !== 1024) begin errors++; $display("FAIL clean_latency: got %0d cycles, want 1024", cyc); end
    checks++;
    if (pass1 !== 1'b1 || err1 !== 16'd0 || fv1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL clean_result: pass=%0b err=%0d fv=%0b busy=%0b, want 1 0 0 1", pass1, err1, fv1, busy1);
    end
    @(posedge clk); #1;
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0 || pass1 !== 1'b1) begin
      errors++;
      $display("FAIL clean_after: done=%0b busy=%0b pass=%0b, want 0 0 1", done1, busy1, pass1);
    end
    checks++;
    if ({a1, b1, cin1} !== 9'h1FF) begin
      errors++;
      $display("FAIL idle_hold: got vec %h, want 1ff", {a1, b1, cin1});
    end
  endtask

  task automatic fault_run(input string name, input int mode, input int k, input int sb);
    int cyc, n_err, first;
    mode1 = mode; kvec1 = k; sbit1 = sb;
    expect_faults(mode, k, sb, n_err, first);
    run1(-1, cyc);
    checks++;
    if (cyc !== 1024 || int'(err1) !== n_err || pass1 !== (n_err == 0)) begin
      errors++;
      $display("FAIL %s_count: cycles=%0d err=%0d pass=%0b, want 1024 %0d %0b",
               name, cyc, err1, pass1, n_err, n_err == 0);
    end
    checks++;
    if (fv1 !== (first >= 0) || (first >= 0 && int'(fvec1) !== first)) begin
      errors++;
      $display("FAIL %s_first: fv=%0b fvec=%h, want %0b %h", name, fv1, fvec1, first >= 0, first);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stuck_faults();
    fault_run("sum0_stuck", 1, 0, 0);
    checks++;
    if (err1 !== 16'd256 || fvec1 !== 9'b000000001) begin
      errors++;
      $display("FAIL sum0_plan: err=%0d fvec=%b, want 256 000000001", err1, fvec1);
    end
    fault_run("cout_stuck", 2, 0, 0);
    checks++;
    if (err1 !== 16'd256 || fvec1 !== 9'b000011111) begin
      errors++;
      $display("FAIL cout_plan: err=%0d fvec=%b, want 256 000011111", err1, fvec1);
    end
  endtask

  task automatic test_random_faults();
    for (int i = 0; i < 3; i++) begin
      fault_run("single_vec", 3, int'($urandom_range(0, 511)), 0);
      fault_run("stuck_bit", 4, 0, int'($urandom_range(0, 4)));
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    // Previous run left errors behind; a new start must wipe them at once.
    mode1 = 0;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    checks++;
    if (err1 !== 16'd0 || fv1 !== 1'b0 || fvec1 !== 9'd0 || pass1 !== 1'b0 || busy1 !== 1'b1 ||
        {a1, b1, cin1} !== 9'd0) begin
      errors++;
      $display("FAIL restart_clear: err=%0d fv=%0b fvec=%h pass=%0b busy=%0b vec=%h, want 0 0 0 0 1 0",
               err1, fv1, fvec1, pass1, busy1, {a1, b1, cin1});
    end
    cyc = 0;
    while (done1 !== 1'b1 && cyc < 5000) begin
      if (cyc == 99) start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      cyc++;
    end
    checks++;
    if (cyc !== 1024 || pass1 !== 1'b1) begin
      errors++;
      $display("FAIL repulse_ignored: cycles=%0d pass=%0b, want 1024 1", cyc, pass1);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    checks++;
    if (pass1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL restart_pass_clear: pass=%0b busy=%0b, want 0 1", pass1, busy1);
    end
    cyc = 0;
    while (done1 !== 1'b1 && cyc < 5000) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
  endtask

  task automatic test_settle3();
    int cyc, runlen, nrec, bad_len, bad_step;
    logic [8:0] prev, cur;
    @(negedge clk) start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    prev = {a3, b3, cin3};
    runlen = 1; nrec = 0; bad_len = 0; bad_step = 0; cyc = 0;
    checks++;
    if (prev !== 9'd0 || busy3 !== 1'b1) begin
      errors++;
      $display("FAIL s3_first_vec: vec=%h busy=%0b, want 0 1", prev, busy3);
    end
    while (done3 !== 1'b1 && cyc < 9000) begin
      @(posedge clk); #1;
      cyc++;
      cur = {a3, b3, cin3};
      if (cur === prev) runlen++;
      else begin
        if (runlen != 4) bad_len++;
        if (cur !== prev + 9'd1) bad_step++;
        nrec++;
        runlen = 1;
        prev = cur;
      end
    end
    checks++;
    if (cyc !== 2048 || pass3 !== 1'b1 || err3 !== 16'd0) begin
      errors++;
      $display("FAIL s3_run: cycles=%0d pass=%0b err=%0d, want 2048 1 0", cyc, pass3, err3);
    end
    checks++;
    if (bad_len != 0 || bad_step != 0 || nrec != 511) begin
      errors++;
      $display("FAIL s3_hold: bad_len=%0d bad_step=%0d changes=%0d, want 0 0 511", bad_len, bad_step, nrec);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun();
    int cyc, done_seen;
    mode1 = 1;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (300) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy1, done1, pass1, fv1, err1, fvec1, a1, b1, cin1} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%0b done=%0b fv=%0b err=%0d fvec=%h vec=%h, want all 0",
               busy1, done1, fv1, err1, fvec1, {a1, b1, cin1});
    end
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) done_seen++;
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 900; i++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1 || busy1 === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL midrun_no_done: done/busy seen %0d times, want 0", done_seen);
    end
    mode1 = 0;
    run1(-1, cyc);
    checks++;
    if (cyc !== 1024 || pass1 !== 1'b1 || err1 !== 16'd0) begin
      errors++;
      $display("FAIL post_reset_run: cycles=%0d pass=%0b err=%0d, want 1024 1 0", cyc, pass1, err1);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    mode1 = 0; kvec1 = 0; sbit1 = 0;
    start1 = 1'b0; start3 = 1'b0;
    rst_n = 1'b0;
    #22;
    test_reset();
    test_clean_run();
    test_stuck_faults();
    test_random_faults();
    test_back_to_back();
    test_settle3();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
